// File: rtl/if_stage_if.sv
// Byte-wide read port between the fetch stage and the shared memory arbiter.
interface if_stage_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_busy;
  logic [7:0]  mem_din;

  modport master (output mem_req, output mem_addr, input mem_busy, input mem_din);
  modport slave  (input mem_req, input mem_addr, output mem_busy, output mem_din);
endinterface

// File: rtl/if_stage.sv
// EPU instruction fetch: assembles 32-bit words from four byte reads and holds them for decode.
// Optional direct-mapped instruction cache enabled by defining IF_ICACHE_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              stall_in,
  input  logic              jump_flag,
  input  logic [31:0]       jump_addr,
  if_stage_if.master        mem,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_ins
);

  typedef enum logic [1:0] {ISSUE, DRAIN, HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_issue_cnt;
  logic [1:0]  r_recv_cnt;
  logic        r_inflight;
  logic [7:0]  r_b0, r_b1, r_b2;

  logic        w_req;
  logic        w_accept;
  logic        w_hit;
  logic [31:0] w_cdat;
  logic [31:0] w_word;

  if ((ICACHE_LINES < 1) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two");
  end

  // Requests are gated by reset and rdy_in so nothing leaks out while frozen.
  assign w_req         = !rst_in && rdy_in && (r_state == ISSUE) && !w_hit;
  assign w_accept      = w_req && !mem.mem_busy;
  assign mem.mem_req   = w_req;
  assign mem.mem_addr  = w_req ? (r_pc + {30'd0, r_issue_cnt}) : 32'h0;
  assign w_word        = {mem.mem_din, r_b2, r_b1, r_b0};

`ifdef IF_ICACHE_EN
  localparam int IDXW = (ICACHE_LINES > 1) ? $clog2(ICACHE_LINES) : 1;
  localparam int TAGW = 30 - IDXW;

  logic [ICACHE_LINES-1:0] r_cv;
  logic [TAGW-1:0]         r_ctag [ICACHE_LINES];
  logic [31:0]             r_cdat [ICACHE_LINES];
  logic [IDXW-1:0]         w_idx;
  logic [TAGW-1:0]         w_tag;
  logic                    w_fill;

  assign w_idx  = r_pc[IDXW+1:2];
  assign w_tag  = r_pc[31:IDXW+2];
  assign w_hit  = (r_state == ISSUE) && (r_issue_cnt == 2'd0) && r_cv[w_idx] && (r_ctag[w_idx] == w_tag);
  assign w_cdat = r_cdat[w_idx];
  // A redirect in the capture cycle kills the fill along with the fetch.
  assign w_fill = rdy_in && !jump_flag && r_inflight && (r_recv_cnt == 2'd3);

  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_ctag[w_idx] <= w_tag;
      r_cdat[w_idx] <= w_word;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_cv        <= '0;
    else if (w_fill) r_cv[w_idx] <= 1'b1;
  end
`else
  assign w_hit  = 1'b0;
  assign w_cdat = 32'h0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= ISSUE;
      r_pc        <= RESET_PC;
      r_issue_cnt <= 2'd0;
      r_recv_cnt  <= 2'd0;
      r_inflight  <= 1'b0;
      r_b0        <= 8'h0;
      r_b1        <= 8'h0;
      r_b2        <= 8'h0;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_ins      <= 32'h0;
    end else if (rdy_in) begin
      // A byte accepted under a redirect belongs to the old stream: never capture it.
      r_inflight <= w_accept && !jump_flag;
      if (jump_flag) begin
        r_pc        <= jump_addr;
        if_valid    <= 1'b0;
        r_issue_cnt <= 2'd0;
        r_recv_cnt  <= 2'd0;
        r_state     <= ISSUE;
      end else begin
        if (r_inflight) begin
          case (r_recv_cnt)
            2'd0: r_b0 <= mem.mem_din;
            2'd1: r_b1 <= mem.mem_din;
            2'd2: r_b2 <= mem.mem_din;
            default: begin
              if_ins   <= w_word;
              if_pc    <= r_pc;
              if_valid <= 1'b1;
              r_state  <= HOLD;
            end
          endcase
          r_recv_cnt <= r_recv_cnt + 2'd1;
        end
        case (r_state)
          ISSUE: begin
            if (w_hit) begin
              if_ins   <= w_cdat;
              if_pc    <= r_pc;
              if_valid <= 1'b1;
              r_state  <= HOLD;
            end else if (w_accept) begin
              r_issue_cnt <= r_issue_cnt + 2'd1;
              if (r_issue_cnt == 2'd3) r_state <= DRAIN;
            end
          end
          HOLD: begin
            if (!stall_in) begin
              if_valid    <= 1'b0;
              r_pc        <= r_pc + 32'd4;
              r_issue_cnt <= 2'd0;
              r_recv_cnt  <= 2'd0;
              r_state     <= ISSUE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: step-by-step reset/fetch checks, a vector table of consume/redirect/busy
// patterns scored against a queue of expected {pc, ins}, and hand-written corner sequences.
module tb_if_stage;
  logic        clk;
  logic        rst_in, rdy_in, stall_in, jump_flag;
  logic [31:0] jump_addr;
  logic        if_valid;
  logic [31:0] if_pc, if_ins;

  if_stage_if bus();

  if_stage dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
    .jump_flag(jump_flag), .jump_addr(jump_addr), .mem(bus),
    .if_valid(if_valid), .if_pc(if_pc), .if_ins(if_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] membyte(input logic [31:0] a);
    case (a)
      32'd0:         return 8'h13;
      32'd1:         return 8'h05;
      32'd2, 32'd3:  return 8'h00;
      default:       return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {membyte(a + 32'd3), membyte(a + 32'd2), membyte(a + 32'd1), membyte(a)};
  endfunction

  // Memory is gated by rdy_in too, so a held byte is re-presented after a freeze.
  always @(posedge clk)
    if (rdy_in && bus.mem_req && !bus.mem_busy) bus.mem_din <= membyte(bus.mem_addr);

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic jmp; logic [31:0] ja; logic [7:0] busy; int lat; } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs [8];
  int          n_vec, n_err;
  logic [31:0] model_pc;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, word(pc)});
  endtask

  // Called in a HOLD cycle: consume (optionally with redirect); returns in the first fetch cycle.
  task automatic consume(input logic jmp, input logic [31:0] ja);
    stall_in  = 1'b0;
    jump_flag = jmp;
    jump_addr = ja;
    model_pc  = jmp ? ja : model_pc + 32'd4;
    push_exp(model_pc);
    step();
    stall_in  = 1'b1;
    jump_flag = 1'b0;
  endtask

  // Waits (bounded) for if_valid, applying a per-cycle busy pattern; scores latency and payload.
  task automatic await_fetch(input logic [7:0] mask, input int exp_lat);
    exp_t e;
    int   k = 0;
    while (!if_valid && k < 40) begin
      bus.mem_busy = (k < 8) ? mask[k] : 1'b0;
      step();
      k++;
    end
    bus.mem_busy = 1'b0;
    chk("latency", k, exp_lat);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: delivery with empty queue, got pc %h", if_pc);
    end else begin
      e = exp_q.pop_front();
      chk("if_pc", if_pc, e.pc);
      chk("if_ins", if_ins, e.ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    vecs[0] = '{1'b0, 32'h0,        8'h00, 5};
    vecs[1] = '{1'b0, 32'h0,        8'h06, 7};
    vecs[2] = '{1'b1, 32'h100,      8'h00, 5};
    vecs[3] = '{1'b0, 32'h0,        8'h01, 6};
    vecs[4] = '{1'b1, 32'hFFFFFFFC, 8'h0A, 7};
    vecs[5] = '{1'b0, 32'h0,        8'h00, 5};
    vecs[6] = '{1'b1, 32'h200,      8'hF0, 5};
    vecs[7] = '{1'b0, 32'h0,        8'h1F, 10};

    rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b1; jump_flag = 1'b0;
    jump_addr = 32'h0; bus.mem_busy = 1'b0;
    repeat (3) step();
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_ins", if_ins, 32'h0);

    // First fetch from reset, cycle by cycle.
    rst_in = 1'b0; #1;
    model_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("fetch0_req", {31'd0, bus.mem_req}, 32'd1);
      chk("fetch0_addr", bus.mem_addr, i);
      step();
    end
    chk("drain_req", {31'd0, bus.mem_req}, 32'd0);
    chk("drain_valid", {31'd0, if_valid}, 32'd0);
    step();
    // Stalled for three cycles: outputs frozen, no requests.
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_ins", if_ins, 32'h00000513);
      chk("hold_pc", if_pc, 32'h0);
      chk("hold_req", {31'd0, bus.mem_req}, 32'd0);
      step();
    end
    consume(1'b0, 32'h0);
    chk("next_addr", bus.mem_addr, 32'h4);
    await_fetch(8'h00, 5);

    for (int v = 0; v < 8; v++) begin
      consume(vecs[v].jmp, vecs[v].ja);
      await_fetch(vecs[v].busy, vecs[v].lat);
    end

    // Redirect in the cycle byte 1 is accepted.
    stall_in = 1'b0;
    step();
    stall_in = 1'b1;
    step();
    jump_flag = 1'b1; jump_addr = 32'h100;
    model_pc = 32'h100;
    push_exp(model_pc);
    step();
    jump_flag = 1'b0;
    chk("jmp_req", {31'd0, bus.mem_req}, 32'd1);
    chk("jmp_addr", bus.mem_addr, 32'h100);
    await_fetch(8'h00, 5);

    // Freeze for four cycles after byte 1 is accepted; stall/jump must be ignored.
    consume(1'b0, 32'h0);
    step();
    step();
    rdy_in = 1'b0; stall_in = 1'b0; jump_flag = 1'b1; jump_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("frz_req", {31'd0, bus.mem_req}, 32'd0);
      chk("frz_valid", {31'd0, if_valid}, 32'd0);
      step();
    end
    rdy_in = 1'b1; stall_in = 1'b1; jump_flag = 1'b0;
    await_fetch(8'h00, 3);

    // Reset asserted mid-fetch.
    stall_in = 1'b0;
    step();
    stall_in = 1'b1;
    step();
    step();
    rst_in = 1'b1; #1;
    chk("mrst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mrst_valid", {31'd0, if_valid}, 32'd0);
    chk("mrst_pc", if_pc, 32'h0);
    step();
    rst_in = 1'b0;
    model_pc = 32'h0;
    push_exp(model_pc);
    await_fetch(8'h00, 5);

`ifdef IF_ICACHE_EN
    // Re-fetch of a cached line: no memory traffic, valid the cycle after issue.
    jump_flag = 1'b1; jump_addr = 32'h0;
    model_pc = 32'h0;
    push_exp(model_pc);
    step();
    jump_flag = 1'b0;
    chk("cache_noreq", {31'd0, bus.mem_req}, 32'd0);
    await_fetch(8'h00, 1);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
